// File: rtl/abuf_rd_sched.sv
// Activation buffer read sequencer: reuse-reads a tile for NROUND-1 rounds, then
// consumes it on the final round, paced by buffer occupancy and MAC readiness.
//
// state  | meaning
// IDLE   | waiting for cfg_start; counters cleared
// REUSE  | non-consuming reads, reuse pointer rewound at end of each round
// FINAL  | consuming reads for the last round
// DONE   | single-cycle completion (ctrl_done, ctrl_err for illegal config)
module abuf_rd_sched #(
  parameter int ABUF_DEPTH = 64,
  parameter int VEC_W      = $clog2(ABUF_DEPTH) + 1,
  parameter int RND_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [VEC_W-1:0] cfg_nvec,
  input  logic [RND_W-1:0] cfg_nround,
  input  logic             cfg_abort,
  output logic             ctrl_busy,
  output logic             ctrl_done,
  output logic             ctrl_err,
  input  logic             abuf_empty,
  input  logic             abuf_reuse_empty,
  input  logic             mac_ready,
  output logic             abuf_ren,
  output logic             abuf_reuse_ren,
  output logic             abuf_reuse_rst,
  output logic             tag_valid,
  output logic             tag_vec_last,
  output logic             tag_rnd_last
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REUSE = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [VEC_W-1:0] VEC_ONE = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [RND_W-1:0] RND_ONE = {{(RND_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] DEPTH_V = VEC_W'(ABUF_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] nvec_q, nvec_d;
  logic [RND_W-1:0] nround_q, nround_d;
  logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic             err_q, err_d;

  logic [VEC_W-1:0] nvec_m1;
  logic [RND_W-1:0] nround_m1;
  logic [RND_W-1:0] rnd_nxt;
  logic             vec_last;
  logic             cfg_bad;
  logic             issue_reuse;
  logic             issue_final;
  logic             issue;

  always_comb begin
    nvec_m1     = nvec_q - VEC_ONE;
    nround_m1   = nround_q - RND_ONE;
    rnd_nxt     = rnd_cnt_q + RND_ONE;
    vec_last    = (vec_cnt_q == nvec_m1);
    cfg_bad     = (cfg_nvec == '0) || (cfg_nround == '0) || (cfg_nvec > DEPTH_V);
    // abort suppresses the read strobes in its own cycle
    issue_reuse = (state_q == ST_REUSE) && mac_ready && !abuf_reuse_empty && !cfg_abort;
    issue_final = (state_q == ST_FINAL) && mac_ready && !abuf_empty && !cfg_abort;
    issue       = issue_reuse || issue_final;
  end

  assign abuf_reuse_ren = issue_reuse;
  assign abuf_reuse_rst = issue_reuse && vec_last;
  assign abuf_ren       = issue_final;
  assign ctrl_busy      = (state_q != ST_IDLE);
  assign ctrl_done      = (state_q == ST_DONE);
  assign ctrl_err       = (state_q == ST_DONE) && err_q;

  always_comb begin
    state_d   = state_q;
    nvec_d    = nvec_q;
    nround_d  = nround_q;
    vec_cnt_d = vec_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          nvec_d    = cfg_nvec;
          nround_d  = cfg_nround;
          vec_cnt_d = '0;
          rnd_cnt_d = '0;
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = (cfg_nround > RND_ONE) ? ST_REUSE : ST_FINAL;
          end
        end
      end
      ST_REUSE: begin
        if (issue) begin
          if (vec_last) begin
            vec_cnt_d = '0;
            rnd_cnt_d = rnd_nxt;
            if (rnd_nxt == nround_m1) state_d = ST_FINAL;
          end else begin
            vec_cnt_d = vec_cnt_q + VEC_ONE;
          end
        end
      end
      ST_FINAL: begin
        if (issue) begin
          if (vec_last) begin
            vec_cnt_d = '0;
            rnd_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            vec_cnt_d = vec_cnt_q + VEC_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase

    // buffer pointers are left where they are; the owner flushes them
    if (cfg_abort) begin
      state_d   = ST_IDLE;
      vec_cnt_d = '0;
      rnd_cnt_d = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      nvec_q       <= '0;
      nround_q     <= '0;
      vec_cnt_q    <= '0;
      rnd_cnt_q    <= '0;
      err_q        <= 1'b0;
      tag_valid    <= 1'b0;
      tag_vec_last <= 1'b0;
      tag_rnd_last <= 1'b0;
    end else begin
      state_q      <= state_d;
      nvec_q       <= nvec_d;
      nround_q     <= nround_d;
      vec_cnt_q    <= vec_cnt_d;
      rnd_cnt_q    <= rnd_cnt_d;
      err_q        <= err_d;
      // tags follow the buffer's one-cycle read latency
      tag_valid    <= issue;
      tag_vec_last <= issue && vec_last;
      tag_rnd_last <= issue_final;
    end
  end

endmodule

// File: tb/tb_abuf_rd_sched.sv
// Directed bench for abuf_rd_sched with a small activation buffer pointer model.
module tb_abuf_rd_sched;

  localparam int ABUF_DEPTH = 64;
  localparam int VEC_W      = $clog2(ABUF_DEPTH) + 1;
  localparam int RND_W      = 8;

  logic             clk;
  logic             rst;
  logic             cfg_start;
  logic [VEC_W-1:0] cfg_nvec;
  logic [RND_W-1:0] cfg_nround;
  logic             cfg_abort;
  logic             ctrl_busy, ctrl_done, ctrl_err;
  logic             abuf_empty, abuf_reuse_empty, mac_ready;
  logic             abuf_ren, abuf_reuse_ren, abuf_reuse_rst;
  logic             tag_valid, tag_vec_last, tag_rnd_last;

  abuf_rd_sched #(.ABUF_DEPTH(ABUF_DEPTH), .VEC_W(VEC_W), .RND_W(RND_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_nvec(cfg_nvec), .cfg_nround(cfg_nround), .cfg_abort(cfg_abort),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .abuf_empty(abuf_empty), .abuf_reuse_empty(abuf_reuse_empty), .mac_ready(mac_ready),
    .abuf_ren(abuf_ren), .abuf_reuse_ren(abuf_reuse_ren), .abuf_reuse_rst(abuf_reuse_rst),
    .tag_valid(tag_valid), .tag_vec_last(tag_vec_last), .tag_rnd_last(tag_rnd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  // buffer model: write, consuming and reuse pointers
  int wr, rd, ru;
  // per-job log
  int cyc_n, n_rd, n_tg, n_done, n_reuse, done_cyc, busy_first, busy_last, viol;
  logic        done_err;
  logic [63:0] kind_v, rst_v, tvl_v, trl_v;
  logic [8:0]  last_out;

  task automatic clear_log();
    cyc_n = 0; n_rd = 0; n_tg = 0; n_done = 0; n_reuse = 0; done_cyc = -1;
    busy_first = -1; busy_last = -1; viol = 0; done_err = 1'b0;
    kind_v = '0; rst_v = '0; tvl_v = '0; trl_v = '0;
  endtask

  // one clock: sample at negedge, update buffer model, drive empties after posedge
  task automatic cyc();
    @(negedge clk);
    last_out = {ctrl_busy, ctrl_done, ctrl_err, abuf_ren, abuf_reuse_ren, abuf_reuse_rst,
                tag_valid, tag_vec_last, tag_rnd_last};
    if (abuf_ren && abuf_reuse_ren) viol++;
    if (abuf_reuse_rst && !abuf_reuse_ren) viol++;
    if (abuf_ren && (abuf_empty || !mac_ready)) viol++;
    if (abuf_reuse_ren && (abuf_reuse_empty || !mac_ready)) viol++;
    if (!tag_valid && (tag_vec_last || tag_rnd_last)) viol++;
    if (ctrl_err && !ctrl_done) viol++;
    if ((abuf_ren || abuf_reuse_ren) && n_rd < 64) begin
      kind_v[n_rd] = abuf_ren;
      rst_v[n_rd]  = abuf_reuse_rst;
      n_rd++;
    end
    if (abuf_reuse_ren) n_reuse++;
    if (tag_valid && n_tg < 64) begin
      tvl_v[n_tg] = tag_vec_last;
      trl_v[n_tg] = tag_rnd_last;
      n_tg++;
    end
    if (ctrl_done) begin
      n_done++;
      done_cyc = cyc_n;
      done_err = ctrl_err;
    end
    if (ctrl_busy) begin
      if (busy_first < 0) busy_first = cyc_n;
      busy_last = cyc_n;
    end
    if (abuf_ren) begin
      rd++;
      ru = rd;
    end
    if (abuf_reuse_ren) ru = abuf_reuse_rst ? rd : ru + 1;
    cyc_n++;
    @(posedge clk);
    #1;
    abuf_empty       = (wr == rd);
    abuf_reuse_empty = (wr == ru);
  endtask

  task automatic start_job(input int nv, input int nr);
    cfg_nvec   = VEC_W'(nv);
    cfg_nround = RND_W'(nr);
    cfg_start  = 1'b1;
    clear_log();
    cyc();
    cfg_start  = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    n_chk++;
    if (last_out !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b exp %b", last_out, 9'b0);
    end
  endtask

  task automatic test_basic();
    mac_ready = 1'b1;
    wr = rd + 4;
    start_job(4, 3);
    run_to_done(40);
    n_chk++;
    if (n_rd !== 12) begin n_fail++; $display("FAIL basic_reads: got %0d exp 12", n_rd); end
    n_chk++;
    if (kind_v[11:0] !== 12'hF00) begin n_fail++; $display("FAIL basic_kind: got %h exp f00", kind_v[11:0]); end
    n_chk++;
    if (rst_v[11:0] !== 12'h088) begin n_fail++; $display("FAIL basic_reuse_rst: got %h exp 088", rst_v[11:0]); end
    n_chk++;
    if (tvl_v[11:0] !== 12'h888 || n_tg !== 12) begin
      n_fail++; $display("FAIL basic_tag_vec_last: got %h/%0d exp 888/12", tvl_v[11:0], n_tg);
    end
    n_chk++;
    if (trl_v[11:0] !== 12'hF00) begin n_fail++; $display("FAIL basic_tag_rnd_last: got %h exp f00", trl_v[11:0]); end
    n_chk++;
    if (done_cyc !== 13 || n_done !== 1 || done_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got cyc %0d cnt %0d err %b exp 13 1 0", done_cyc, n_done, done_err);
    end
    n_chk++;
    if (busy_first !== 1 || busy_last !== 13) begin
      n_fail++; $display("FAIL basic_busy: got %0d..%0d exp 1..13", busy_first, busy_last);
    end
    n_chk++;
    if (viol !== 0) begin n_fail++; $display("FAIL basic_rules: got %0d exp 0", viol); end
  endtask

  task automatic test_single_round();
    wr = rd + 2;
    start_job(2, 1);
    run_to_done(20);
    n_chk++;
    if (n_rd !== 2 || kind_v[1:0] !== 2'b11 || n_reuse !== 0 || rst_v[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL single_reads: got n %0d kind %b reuse %0d exp 2 11 0", n_rd, kind_v[1:0], n_reuse);
    end
    n_chk++;
    if (done_cyc !== 3) begin n_fail++; $display("FAIL single_done: got %0d exp 3", done_cyc); end
  endtask

  task automatic test_flow_control();
    int wrote;
    wrote = 0;
    mac_ready = 1'b1;
    start_job(4, 2);
    for (int k = 0; k < 150 && n_done == 0; k++) begin
      if (k % 3 == 0 && wrote < 4) begin
        wr++;
        wrote++;
      end
      mac_ready = (k % 2 == 0);
      cyc();
    end
    mac_ready = 1'b1;
    cyc();
    n_chk++;
    if (n_rd !== 8 || kind_v[7:0] !== 8'hF0 || rst_v[7:0] !== 8'h08) begin
      n_fail++; $display("FAIL flow_reads: got n %0d kind %h rst %h exp 8 f0 08", n_rd, kind_v[7:0], rst_v[7:0]);
    end
    n_chk++;
    if (n_tg !== 8 || tvl_v[7:0] !== 8'h88 || trl_v[7:0] !== 8'hF0) begin
      n_fail++; $display("FAIL flow_tags: got n %0d vl %h rl %h exp 8 88 f0", n_tg, tvl_v[7:0], trl_v[7:0]);
    end
    n_chk++;
    if (viol !== 0 || n_done !== 1) begin
      n_fail++; $display("FAIL flow_rules: got viol %0d done %0d exp 0 1", viol, n_done);
    end
  endtask

  task automatic test_illegal();
    int nv[3] = '{0, 65, 4};
    int nr[3] = '{3, 2, 0};
    mac_ready = 1'b1;
    wr = rd + 4;
    for (int i = 0; i < 3; i++) begin
      start_job(nv[i], nr[i]);
      repeat (5) cyc();
      n_chk++;
      if (done_cyc !== 1 || done_err !== 1'b1 || n_done !== 1 || n_rd !== 0) begin
        n_fail++;
        $display("FAIL illegal_%0d: got done %0d err %b cnt %0d reads %0d exp 1 1 1 0", i, done_cyc, done_err, n_done, n_rd);
      end
    end
  endtask

  task automatic test_abort();
    mac_ready = 1'b1;
    wr = rd + 8;
    start_job(8, 2);
    for (int k = 0; k < 20 && n_rd < 3; k++) cyc();
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    n_chk++;
    if (n_rd !== 3 || n_reuse !== 3) begin n_fail++; $display("FAIL abort_reads: got %0d exp 3", n_rd); end
    n_chk++;
    if (n_tg !== 3) begin n_fail++; $display("FAIL abort_tag: got %0d exp 3", n_tg); end
    n_chk++;
    if (n_done !== 0 || viol !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got done %0d viol %0d exp 0 0", n_done, viol);
    end
    start_job(2, 1);
    run_to_done(20);
    n_chk++;
    if (done_cyc !== 3 || n_rd !== 2 || busy_first !== 1) begin
      n_fail++; $display("FAIL abort_restart: got done %0d reads %0d busy %0d exp 3 2 1", done_cyc, n_rd, busy_first);
    end
  endtask

  task automatic test_reset_in_final();
    mac_ready = 1'b1;
    wr = rd + 4;
    start_job(4, 1);
    cyc();
    cyc();
    rst = 1'b1;
    cfg_nvec = VEC_W'(2);
    cfg_nround = RND_W'(1);
    cfg_start = 1'b1;
    cyc();
    rst = 1'b0;
    cfg_start = 1'b0;
    cyc();
    n_chk++;
    if (last_out !== 9'b0) begin n_fail++; $display("FAIL rst_final_outputs: got %b exp %b", last_out, 9'b0); end
    repeat (4) cyc();
    n_chk++;
    if (n_done !== 0 || busy_last !== 3) begin
      n_fail++; $display("FAIL rst_final_start_ignored: got done %0d busy_last %0d exp 0 3", n_done, busy_last);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    wr = 0; rd = 0; ru = 0;
    rst = 1'b1; cfg_start = 1'b0; cfg_nvec = '0; cfg_nround = '0; cfg_abort = 1'b0;
    abuf_empty = 1'b1; abuf_reuse_empty = 1'b1; mac_ready = 1'b0;
    clear_log();
    test_reset();
    test_basic();
    test_single_round();
    test_flow_control();
    test_illegal();
    test_abort();
    test_reset_in_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/abuf_rd_sched.md
Name: abuf_rd_sched

Overview:
- Read sequencer for the core activation buffer. For one tile of NVEC activation vectors used NROUND times, it drives the buffer's non-consuming reuse-read port for the first NROUND-1 rounds and the consuming read port for the final round.
- Sits between the core control FSM (configuration, start, done) and the activation buffer / MAC array.
- Paces every issue on buffer occupancy and on MAC readiness.
- Emits per-read tags aligned with the buffer's one-cycle read latency.

Parameters:
- ABUF_DEPTH, 64, activation buffer depth in vectors; upper legal bound for cfg_nvec.
- VEC_W, $clog2(ABUF_DEPTH)+1, width of the vector count.
- RND_W, 8, width of the round count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_nvec  in  VEC_W  vectors per round; sampled with cfg_start.
- cfg_nround  in  RND_W  total rounds (reuse rounds + final round); sampled with cfg_start.
- cfg_abort  in  1  synchronous abort of the current job.
- ctrl_busy  out  1  high from the cycle after an accepted start until DONE is left.
- ctrl_done  out  1  one-cycle pulse at job completion.
- ctrl_err  out  1  one-cycle pulse, concurrent with ctrl_done, when the config is illegal.
- abuf_empty  in  1  buffer empty relative to the consuming read pointer.
- abuf_reuse_empty  in  1  buffer empty relative to the reuse pointer.
- mac_ready  in  1  MAC array can accept a vector next cycle.
- abuf_ren  out  1  consuming read.
- abuf_reuse_ren  out  1  non-consuming reuse read.
- abuf_reuse_rst  out  1  rewind the reuse pointer to the consuming read pointer; only ever asserted together with abuf_reuse_ren.
- tag_valid  out  1  registered copy of any read issue; equals the buffer's rvalid.
- tag_vec_last  out  1  registered flag: the issued read was vector cfg_nvec-1 of its round.
- tag_rnd_last  out  1  registered flag: the issued read belongs to the final round.

Behaviour:
- Reset: state IDLE, all counters 0. Every output is 0 from the cycle after rst is sampled high.
- States: IDLE, REUSE, FINAL, DONE.
- Latched at start: nvec_q, nround_q. Counters: vec_cnt (VEC_W bits), rnd_cnt (RND_W bits).
- IDLE:
  - cfg_start with cfg_nvec==0, cfg_nround==0, or cfg_nvec>ABUF_DEPTH: go to DONE; ctrl_err pulses with ctrl_done; no read is ever issued.
  - Otherwise legal start: go to REUSE if cfg_nround>1, else FINAL.
  - cfg_start in any state other than IDLE is ignored.
- Issue condition (combinational, from registered state):
  - REUSE: issue = mac_ready & ~abuf_reuse_empty; abuf_reuse_ren = issue.
  - FINAL: issue = mac_ready & ~abuf_empty; abuf_ren = issue.
  - abuf_ren and abuf_reuse_ren are never high in the same cycle. Both are 0 in IDLE and DONE.
- On each issue, vec_cnt increments.
- At vec_cnt==nvec_q-1 in REUSE:
  - abuf_reuse_rst=1 in the same cycle as abuf_reuse_ren.
  - vec_cnt goes to 0 and rnd_cnt increments.
  - If rnd_cnt+1==nround_q-1, go to FINAL.
- At vec_cnt==nvec_q-1 in FINAL: go to DONE.
- DONE: lasts exactly one cycle. ctrl_done=1 (ctrl_err=1 only for an illegal config), then IDLE.
- Stall: no issue leaves all counters unchanged. There is no timeout.
- Tags: registered one cycle after the issue, so they align with the read data.
  - tag_valid is 1 only in the cycle after an issue.
  - tag_vec_last and tag_rnd_last are 0 whenever tag_valid is 0.
- Throughput: one read per cycle when unstalled. A job of N vectors × R rounds with no stalls takes N·R issue cycles plus the DONE cycle. The first issue is possible in the cycle after cfg_start.
- Round-boundary guarantee: the read issued with abuf_reuse_rst uses the pre-rewind address. The next round's first read uses the rewound address with no bubble.
- Abort: cfg_abort (lower priority than rst) forces IDLE next cycle.
  - Counters are cleared; no ctrl_done and no ctrl_err.
  - abuf_ren, abuf_reuse_ren and abuf_reuse_rst are 0 in the abort cycle.
  - An issue registered in the previous cycle still produces its tag.
  - Buffer pointers are not rewound; flushing them is the owner's responsibility.
- Width rules: comparisons use the latched values. nround_q-1 is computed in RND_W bits and is only used when nround_q≥1. cfg_nvec==ABUF_DEPTH is legal.

Test Plan:
- Basic job: nvec=4, nround=3, buffer preloaded with 4 vectors, mac_ready=1 → expect:
  - 8 reuse reads, with abuf_reuse_rst on reads 4 and 8;
  - then 4 abuf_ren reads;
  - ctrl_done in cycle 13 after start;
  - tag_vec_last on reads 4, 8 and 12; tag_rnd_last on reads 9–12.
- Single round: nround=1, nvec=2 → exactly 2 abuf_ren, no abuf_reuse_ren and no abuf_reuse_rst; done 3 cycles after start.
- Flow control: nvec=4, nround=2, data written one vector every 3 cycles, mac_ready toggling 1/0 → every issue coincides with ~empty & mac_ready; total issues equal 8; the tag sequence is unchanged.
- Illegal configs: nvec=0, then nvec=65 (ABUF_DEPTH=64), then nround=0 → each gives ctrl_done and ctrl_err in the cycle after start, with zero reads.
- Abort mid-round: nvec=8, nround=2, cfg_abort after 3 reuse reads → reads stop the same cycle; no done; a new start 1 cycle later is accepted.
- rst asserted during FINAL and held 1 cycle → all outputs 0 the next cycle; a start pulse with rst high is ignored.
